// File: rtl/sig_rate_ctrl_pkg.sv
// sig_rate_ctrl_pkg: shared encodings, rate tables, error codes and FSM states
// for the SIGNAL/HT-SIG post-decode sequencer.
package sig_rate_ctrl_pkg;
   localparam int DIVD_W = 20;
   localparam int DVS_W = 9;
   localparam int QUO_W = 16;
   localparam logic [1:0] MOD_BPSK = 2'd0, MOD_QPSK = 2'd1, MOD_16QAM = 2'd2, MOD_64QAM = 2'd3;
   localparam logic [1:0] CR_1_2 = 2'd0, CR_2_3 = 2'd1, CR_3_4 = 2'd2, CR_5_6 = 2'd3;
   localparam logic [2:0] ERR_NONE = 3'd0, ERR_PARITY = 3'd1, ERR_RSVD = 3'd2,
                          ERR_RATE = 3'd3, ERR_LEN = 3'd4, ERR_TIMEOUT = 3'd5;
   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LOOKUP, S_DIVIDE, S_DONE, S_ERROR} state_t;
   typedef struct packed {
      logic [1:0]       mod;
      logic [1:0]       code_rate;
      logic [DVS_W-1:0] n_dbps;
   } phy_cfg_t;
   localparam phy_cfg_t LEG_TBL [8] = '{
      '{MOD_BPSK,  CR_1_2, 9'd24},  '{MOD_BPSK,  CR_3_4, 9'd36},
      '{MOD_QPSK,  CR_1_2, 9'd48},  '{MOD_QPSK,  CR_3_4, 9'd72},
      '{MOD_16QAM, CR_1_2, 9'd96},  '{MOD_16QAM, CR_3_4, 9'd144},
      '{MOD_64QAM, CR_2_3, 9'd192}, '{MOD_64QAM, CR_3_4, 9'd216}};
   localparam phy_cfg_t HT_TBL [8] = '{
      '{MOD_BPSK,  CR_1_2, 9'd26},  '{MOD_QPSK,  CR_1_2, 9'd52},
      '{MOD_QPSK,  CR_3_4, 9'd78},  '{MOD_16QAM, CR_1_2, 9'd104},
      '{MOD_16QAM, CR_3_4, 9'd156}, '{MOD_64QAM, CR_2_3, 9'd208},
      '{MOD_64QAM, CR_3_4, 9'd234}, '{MOD_64QAM, CR_5_6, 9'd260}};

   function automatic phy_cfg_t cfg_lookup(input logic ht, input logic [2:0] idx);
      return ht ? HT_TBL[idx] : LEG_TBL[idx];
   endfunction

   // First failing check wins: parity, reserved/tail, rate, length.
   function automatic logic [2:0] legacy_err(input logic [23:0] s);
      return (^s[17:0]) ? ERR_PARITY :
             (s[4] || s[23:18] != 6'd0) ? ERR_RSVD :
             !s[3] ? ERR_RATE :
             (s[16:5] == 12'd0) ? ERR_LEN : ERR_NONE;
   endfunction

   function automatic logic [2:0] ht_err(input logic [6:0] mcs, input logic [15:0] len);
      return (mcs > 7'd7) ? ERR_RATE : (len == 16'd0) ? ERR_LEN : ERR_NONE;
   endfunction
endpackage

// File: rtl/sig_rate_ctrl_sym_count_div.sv
// sym_count_div: iterative ceil-divider; one subtraction per enabled cycle,
// done is asserted in the last cycle with quotient = ceil(dividend/divisor).
module sym_count_div
   import sig_rate_ctrl_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              start,
   input  logic [DIVD_W-1:0] dividend,
   input  logic [DVS_W-1:0]  divisor,
   output logic              done,
   output logic [QUO_W-1:0]  quotient
);
   logic              running;
   logic [DIVD_W-1:0] rem;
   logic [DVS_W-1:0]  dvs;
   logic [QUO_W-1:0]  cnt;

   assign done = enable && running && rem <= DIVD_W'(dvs);
   assign quotient = cnt + 1'b1;

   always_ff @(posedge clock)
      if (reset) begin
         running <= 1'b0;
         rem <= '0;
         dvs <= '0;
         cnt <= '0;
      end else if (enable) begin
         if (start) begin
            running <= 1'b1;
            rem <= dividend;
            dvs <= divisor;
            cnt <= '0;
         end else if (running) begin
            cnt <= cnt + 1'b1;
            rem <= rem - DIVD_W'(dvs);
            running <= !done;
         end
      end
endmodule

// File: rtl/sig_rate_ctrl.sv
// sig_rate_ctrl: validates legacy SIGNAL / HT-SIG fields, runs the rate lookup
// handshake, maps the index to demod config and counts OFDM symbols.
module sig_rate_ctrl
   import sig_rate_ctrl_pkg::*;
#(
   parameter int LOOKUP_TIMEOUT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [23:0] sig_bits,
   input  logic        sig_strobe,
   input  logic [6:0]  ht_mcs,
   input  logic [15:0] ht_len,
   input  logic        ht_strobe,
   output logic [7:0]  rate_out,
   output logic        rate_strobe,
   input  logic [7:0]  idx_in,
   input  logic        idx_strobe,
   output logic [1:0]  mod,
   output logic [1:0]  code_rate,
   output logic [8:0]  n_dbps,
   output logic [15:0] n_sym,
   output logic [15:0] pkt_len,
   output logic        is_ht,
   output logic        cfg_strobe,
   output logic        err_strobe,
   output logic [2:0]  err_code,
   output logic        drop_strobe,
   output logic        busy
);
   localparam int TW = $clog2(LOOKUP_TIMEOUT + 1);

   state_t           state, nxt;
   logic             cap_ht;
   logic [7:0]       cap_rate;
   logic [15:0]      cap_len;
   logic [2:0]       cap_err;
   logic [TW-1:0]    tmr;
   logic             accept, tmo, div_start, div_done, unused_idx;
   logic [QUO_W-1:0] div_q;
   phy_cfg_t         cur_cfg, idx_cfg;

   assign accept = state == S_IDLE && (sig_strobe || ht_strobe);
   assign tmo = tmr == TW'(LOOKUP_TIMEOUT - 1);
   assign idx_cfg = cfg_lookup(cap_ht, idx_in[2:0]);
   assign div_start = enable && state == S_LOOKUP && idx_strobe;
   assign unused_idx = ^idx_in[7:3];
   assign rate_out = cap_rate;

   sym_count_div u_div (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .start    (div_start),
      .dividend (DIVD_W'({cap_len, 3'b000}) + DIVD_W'(22)),
      .divisor  (idx_cfg.n_dbps),
      .done     (div_done),
      .quotient (div_q)
   );

   always_ff @(posedge clock)
      if (reset) state <= S_IDLE;
      else if (enable) state <= nxt;

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:   nxt = accept ? S_CHECK : S_IDLE;
         S_CHECK:  nxt = cap_err != ERR_NONE ? S_ERROR : S_LOOKUP;
         S_LOOKUP: nxt = idx_strobe ? S_DIVIDE : tmo ? S_ERROR : S_LOOKUP;
         S_DIVIDE: nxt = div_done ? S_DONE : S_DIVIDE;
         default:  nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = state != S_IDLE;
      rate_strobe = enable && state == S_LOOKUP && tmr == '0;
      cfg_strobe = enable && state == S_DONE;
      err_strobe = enable && state == S_ERROR;
      drop_strobe = enable && (busy ? (sig_strobe || ht_strobe) : (sig_strobe && ht_strobe));
   end

   always_ff @(posedge clock)
      if (reset) begin
         cap_ht <= 1'b0;
         cap_rate <= '0;
         cap_len <= '0;
         cap_err <= ERR_NONE;
         tmr <= '0;
         cur_cfg <= '0;
         err_code <= ERR_NONE;
         mod <= '0;
         code_rate <= '0;
         n_dbps <= '0;
         n_sym <= '0;
         pkt_len <= '0;
         is_ht <= 1'b0;
      end else if (enable) begin
         if (accept) begin
            cap_ht <= !sig_strobe;
            cap_rate <= sig_strobe ? {4'd0, sig_bits[3:0]} : {1'b1, ht_mcs};
            cap_len <= sig_strobe ? {4'd0, sig_bits[16:5]} : ht_len;
            cap_err <= sig_strobe ? legacy_err(sig_bits) : ht_err(ht_mcs, ht_len);
         end
         tmr <= state == S_LOOKUP ? tmr + 1'b1 : '0;
         if (div_start) cur_cfg <= idx_cfg;
         if (nxt == S_ERROR) err_code <= state == S_CHECK ? cap_err : ERR_TIMEOUT;
         if (nxt == S_DONE) begin
            mod <= cur_cfg.mod;
            code_rate <= cur_cfg.code_rate;
            n_dbps <= cur_cfg.n_dbps;
            n_sym <= div_q;
            pkt_len <= cap_len;
            is_ht <= cap_ht;
         end
      end
endmodule

// File: tb/tb_sig_rate_ctrl.sv
// tb_sig_rate_ctrl: directed checks of the SIGNAL/HT-SIG sequencer.
module tb_sig_rate_ctrl;
   logic        clock = 1'b0;
   logic        reset, enable;
   logic [23:0] sig_bits;
   logic        sig_strobe;
   logic [6:0]  ht_mcs;
   logic [15:0] ht_len;
   logic        ht_strobe;
   logic [7:0]  rate_out;
   logic        rate_strobe;
   logic [7:0]  idx_in;
   logic        idx_strobe;
   logic [1:0]  mod, code_rate;
   logic [8:0]  n_dbps;
   logic [15:0] n_sym, pkt_len;
   logic        is_ht, cfg_strobe, err_strobe, drop_strobe, busy;
   logic [2:0]  err_code;
   int          errors = 0, checks = 0;
   int          n;
   logic        got_cfg, got_err;

   always #5 clock = ~clock;

   sig_rate_ctrl #(.LOOKUP_TIMEOUT(4)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .sig_bits(sig_bits), .sig_strobe(sig_strobe),
      .ht_mcs(ht_mcs), .ht_len(ht_len), .ht_strobe(ht_strobe),
      .rate_out(rate_out), .rate_strobe(rate_strobe),
      .idx_in(idx_in), .idx_strobe(idx_strobe),
      .mod(mod), .code_rate(code_rate), .n_dbps(n_dbps), .n_sym(n_sym),
      .pkt_len(pkt_len), .is_ht(is_ht), .cfg_strobe(cfg_strobe),
      .err_strobe(err_strobe), .err_code(err_code),
      .drop_strobe(drop_strobe), .busy(busy)
   );

   task automatic tick(input int k = 1);
      repeat (k) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic send_sig(input logic [23:0] b);
      sig_bits = b;
      sig_strobe = 1'b1;
      tick();
      sig_strobe = 1'b0;
   endtask

   task automatic send_ht(input logic [6:0] m, input logic [15:0] l);
      ht_mcs = m;
      ht_len = l;
      ht_strobe = 1'b1;
      tick();
      ht_strobe = 1'b0;
   endtask

   task automatic lookup(input string tag, input logic [7:0] exp_rate, input logic [7:0] idx);
      tick();
      chk({tag, "_rstb"}, 32'(rate_strobe), 1);
      chk({tag, "_rate"}, 32'(rate_out), 32'(exp_rate));
      tick();
      chk({tag, "_rstb_pulse"}, 32'(rate_strobe), 0);
      idx_in = idx;
      idx_strobe = 1'b1;
      tick();
      idx_strobe = 1'b0;
   endtask

   task automatic wait_out(input int lim, output int cnt, output logic c, output logic e);
      cnt = 0;
      while (cnt < lim && !cfg_strobe && !err_strobe) begin
         tick();
         cnt++;
      end
      c = cfg_strobe;
      e = err_strobe;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; enable = 1'b1;
      sig_bits = '0; sig_strobe = 1'b0;
      ht_mcs = '0; ht_len = '0; ht_strobe = 1'b0;
      idx_in = '0; idx_strobe = 1'b0;
      tick(2);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_nsym", 32'(n_sym), 0);
      chk("rst_rate", 32'(rate_out), 0);
      chk("rst_strobes", 32'({rate_strobe, cfg_strobe, err_strobe, drop_strobe}), 0);
      reset = 1'b0;
      tick();

      // legacy 6M, len 100
      send_sig(24'h000C8B);
      chk("l6_busy", 32'(busy), 1);
      lookup("l6", 8'h0B, 8'd0);
      wait_out(200, n, got_cfg, got_err);
      chk("l6_cfg", 32'(got_cfg), 1);
      chk("l6_lat", 32'(n + 4), 39);
      chk("l6_mod", 32'(mod), 0);
      chk("l6_cr", 32'(code_rate), 0);
      chk("l6_dbps", 32'(n_dbps), 24);
      chk("l6_nsym", 32'(n_sym), 35);
      chk("l6_len", 32'(pkt_len), 100);
      chk("l6_ht", 32'(is_ht), 0);
      tick();
      chk("l6_cfg_pulse", 32'(cfg_strobe), 0);
      chk("l6_idle", 32'(busy), 0);

      // legacy 54M, len 1500
      send_sig(24'h02BB8C);
      lookup("l54", 8'h0C, 8'd7);
      wait_out(200, n, got_cfg, got_err);
      chk("l54_cfg", 32'(got_cfg), 1);
      chk("l54_n", 32'(n), 56);
      chk("l54_mod", 32'(mod), 3);
      chk("l54_cr", 32'(code_rate), 2);
      chk("l54_dbps", 32'(n_dbps), 216);
      chk("l54_nsym", 32'(n_sym), 56);
      chk("l54_len", 32'(pkt_len), 1500);
      tick();

      // rejections
      send_sig(24'h020C8B);
      wait_out(10, n, got_cfg, got_err);
      chk("par_err", 32'({got_cfg, got_err}), 1);
      chk("par_n", 32'(n), 1);
      chk("par_code", 32'(err_code), 1);
      chk("par_keep", 32'(n_sym), 56);
      tick();
      send_sig(24'h02000B);
      wait_out(10, n, got_cfg, got_err);
      chk("len_err", 32'({got_cfg, got_err}), 1);
      chk("len_code", 32'(err_code), 4);
      tick();
      send_ht(7'd9, 16'd100);
      wait_out(10, n, got_cfg, got_err);
      chk("mcs_err", 32'({got_cfg, got_err}), 1);
      chk("mcs_code", 32'(err_code), 3);
      tick();
      chk("err_idle", 32'(busy), 0);

      // HT MCS7 max length, with a dropped SIGNAL at DIVIDE cycle 10
      send_ht(7'd7, 16'hFFFF);
      lookup("ht", 8'h87, 8'd7);
      tick(9);
      sig_bits = 24'h000C8B;
      sig_strobe = 1'b1;
      #1;
      chk("ht_drop", 32'(drop_strobe), 1);
      tick();
      sig_strobe = 1'b0;
      wait_out(3000, n, got_cfg, got_err);
      chk("ht_cfg", 32'({got_cfg, got_err}), 2);
      chk("ht_n", 32'(n), 2007);
      chk("ht_nsym", 32'(n_sym), 2017);
      chk("ht_dbps", 32'(n_dbps), 260);
      chk("ht_cr", 32'(code_rate), 3);
      chk("ht_mod", 32'(mod), 3);
      chk("ht_is", 32'(is_ht), 1);
      chk("ht_len", 32'(pkt_len), 65535);
      tick();
      chk("ht_idle", 32'(busy), 0);

      // both strobes in IDLE, then the lookup never answers
      sig_bits = 24'h000C8B;
      ht_mcs = 7'd3;
      ht_len = 16'd10;
      sig_strobe = 1'b1;
      ht_strobe = 1'b1;
      #1;
      chk("both_drop", 32'(drop_strobe), 1);
      tick();
      sig_strobe = 1'b0;
      ht_strobe = 1'b0;
      tick();
      chk("to_rstb", 32'(rate_strobe), 1);
      chk("to_legacy", 32'(rate_out), 32'h0B);
      wait_out(20, n, got_cfg, got_err);
      chk("to_err", 32'({got_cfg, got_err}), 1);
      chk("to_n", 32'(n), 4);
      chk("to_code", 32'(err_code), 5);
      tick();
      chk("to_idle", 32'(busy), 0);

      // reset mid-DIVIDE
      send_sig(24'h000C8B);
      lookup("rs", 8'h0B, 8'd0);
      tick(5);
      reset = 1'b1;
      tick();
      chk("rs_nsym", 32'(n_sym), 0);
      chk("rs_cfg", 32'({mod, code_rate, n_dbps}), 0);
      chk("rs_len", 32'({pkt_len, is_ht}), 0);
      chk("rs_err", 32'(err_code), 0);
      chk("rs_busy", 32'(busy), 0);
      chk("rs_strobes", 32'({cfg_strobe, err_strobe, rate_strobe}), 0);
      reset = 1'b0;
      wait_out(50, n, got_cfg, got_err);
      chk("rs_quiet", 32'({got_cfg, got_err}), 0);

      // next SIGNAL completes, stretched by 5 frozen cycles
      send_sig(24'h02BB8C);
      lookup("en", 8'h0C, 8'd7);
      tick(10);
      enable = 1'b0;
      sig_strobe = 1'b1;
      #1;
      chk("en_nodrop", 32'(drop_strobe), 0);
      chk("en_busy", 32'(busy), 1);
      sig_strobe = 1'b0;
      tick(5);
      enable = 1'b1;
      wait_out(200, n, got_cfg, got_err);
      chk("en_cfg", 32'({got_cfg, got_err}), 2);
      chk("en_lat", 32'(n + 19), 65);
      chk("en_nsym", 32'(n_sym), 56);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sig_rate_ctrl.md
Name: sig_rate_ctrl

Overview:
Sequences the SIGNAL/HT-SIG post-decode flow. Accepts a decoded legacy SIGNAL word or an HT MCS/length pair and validates it. It then drives the rate-to-index lookup over a strobe handshake, maps the returned index to demod parameters, and computes the OFDM symbol count with an iterative subtractor. It sits between the SIGNAL decoder and the demod/deinterleave/Viterbi config inputs.

Parameters:
LOOKUP_TIMEOUT, 4, cycles to wait for idx_strobe after rate_strobe before aborting.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
enable  in  1  low freezes all state; strobes ignored, strobe outputs forced 0
sig_bits  in  24  legacy SIGNAL: [3:0] rate, [4] reserved, [16:5] length, [17] parity, [23:18] tail
sig_strobe  in  1  sig_bits valid
ht_mcs  in  7  HT MCS
ht_len  in  16  HT PSDU length (bytes)
ht_strobe  in  1  ht_mcs/ht_len valid
rate_out  out  8  to lookup: {0,3'b0,rate} legacy, {1,mcs} HT
rate_strobe  out  1  lookup request, 1-cycle pulse
idx_in  in  8  lookup result
idx_strobe  in  1  idx_in valid
mod  out  2  0 BPSK, 1 QPSK, 2 16QAM, 3 64QAM
code_rate  out  2  0 1/2, 1 2/3, 2 3/4, 3 5/6
n_dbps  out  9  data bits per symbol
n_sym  out  16  symbol count
pkt_len  out  16  length in bytes
is_ht  out  1  config is HT
cfg_strobe  out  1  config outputs valid, 1-cycle pulse
err_strobe  out  1  1-cycle pulse on rejection
err_code  out  3  1 parity, 2 reserved/tail nonzero, 3 bad rate (legacy rate[3]=0 or MCS>7), 4 zero length, 5 lookup timeout
drop_strobe  out  1  input strobe ignored while busy
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; FSM to IDLE. Reset mid-operation aborts with no cfg/err pulse.
- FSM states and transitions:
  - IDLE: sig_strobe or ht_strobe captures fields, go to CHECK. Both strobes in the same cycle: legacy wins, HT drops with a drop_strobe pulse.
  - CHECK (1 cycle):
    - Legacy check order: parity (even over bits[17:0]), then bit4 or tail nonzero, then rate[3]=0, then length=0.
    - HT check order: MCS>7, then length=0.
    - Any failure goes to ERROR; otherwise go to LOOKUP.
  - LOOKUP: rate_strobe pulses on the first cycle. Wait for idx_strobe; a timeout counter expiring after LOOKUP_TIMEOUT cycles goes to ERROR code 5. idx_strobe outside LOOKUP is ignored.
  - DIVIDE:
    - Setup: total = 16 + 8*len + 6, 20-bit unsigned; rem = total; cnt = 0.
    - Each cycle: cnt++. If rem <= n_dbps, go to DONE; else rem -= n_dbps.
    - Result: n_sym = ceil(total/n_dbps), taking n_sym cycles.
  - DONE: cfg_strobe = 1 for one cycle; outputs hold until the next DONE or reset. Go to IDLE.
  - ERROR: err_strobe = 1 with err_code for one cycle; config outputs unchanged. Go to IDLE.
- Timing with a 1-cycle lookup, input strobe sampled at edge T:
  - rate_strobe high in cycle T+2.
  - idx_strobe in cycle T+3.
  - DIVIDE occupies cycles T+4..T+3+n_sym.
  - cfg_strobe high in cycle T+4+n_sym.
- Any sig/ht strobe while busy: drop_strobe pulse; the in-flight transaction is unaffected.
- Parameter tables, indexed by idx[2:0] → (mod, code_rate, n_dbps):
  - Legacy: 0 (0,0,24), 1 (0,2,36), 2 (1,0,48), 3 (1,2,72), 4 (2,0,96), 5 (2,2,144), 6 (3,1,192), 7 (3,2,216).
  - HT: 0 (0,0,26), 1 (1,0,52), 2 (1,2,78), 3 (2,0,104), 4 (2,2,156), 5 (3,1,208), 6 (3,2,234), 7 (3,3,260).
- Worst case: HT MCS0, len 65535 gives n_sym = 20166, which fits 16 bits.

Decomposition:
- Shared package holds: mod and code_rate encodings, err_code constants, both n_dbps/mod/rate tables, and the FSM state enum.
- One sub-module, sym_count_div: iterative ceil-divider with start/done handshake (20-bit dividend, 9-bit divisor, 16-bit quotient).

Test Plan:
- Legacy 6M, sig_bits=0x000C8B (rate 0xB, len 100): rate_out=0x0B; lookup returns 0; cfg: mod 0, code_rate 0, n_dbps 24, n_sym 35, pkt_len 100, is_ht 0. cfg_strobe 39 cycles after sig_strobe.
- Legacy 54M, sig_bits=0x02BB8C (len 1500, parity 1): idx 7; mod 3, code_rate 2, n_dbps 216, n_sym 56.
- Error checks: sig_bits=0x020C8B gives err_code 1 with no cfg_strobe; then len 0 with rate 0xB gives err_code 4; then HT MCS 9 gives err_code 3.
- HT MCS7, len 65535: rate_out=0x87; n_dbps 260, code_rate 3, n_sym 2017, is_ht 1. A sig_strobe at DIVIDE cycle 10 produces drop_strobe, and the result is unchanged.
- Lookup stub never strobes: err_code 5 exactly LOOKUP_TIMEOUT cycles after rate_strobe; busy then returns 0.
- Reset asserted mid-DIVIDE: all outputs 0 the next cycle, no cfg or err pulse. The next valid SIGNAL completes normally. enable low for 5 cycles mid-DIVIDE stretches latency by exactly 5.
